eeprom_slave: RTL and testbench
===============================

Name: eeprom_slave

Overview:
- Synthesizable I2C-style serial EEPROM responder: the device end of the two-wire protocol that the EEPROM_WR master drives.
- Oversamples SCL/SDA with the local clock, detects START/STOP, and decodes control, address and data bytes.
- Writes into or reads from an internal 2K x 8 array, ACKing and driving SDA open-drain.
- Serves as a bench model for EEPROM_WR and as an on-chip EEPROM emulator.

Parameters:
- MEM_AW, 11, address width; array depth 2**MEM_AW bytes; ctrl byte carries ADDR[10:8], address byte carries ADDR[7:0].
- DEV_TYPE, 4'b1010, device-type nibble expected in ctrl byte bits [7:4].
- SYNC_STAGES, 2, synchronizer flops on SCL and SDA inputs (min 2).

Ports:
- CLK  input  1  system clock; must be >= 8x SCL frequency.
- RESET  input  1  synchronous, active-high reset.
- SCL  input  1  serial clock from master.
- SDA  inout  1  serial data, open-drain: driven 0 or released to 'z', never driven 1.
- BUSY  output  1  high from accepted START until STOP or return to IDLE.
- WR_STROBE  output  1  one-CLK pulse when a data byte is committed to the array.
- WR_ADDR  output  MEM_AW  address of the last committed write; valid with WR_STROBE.

Behaviour:
- Reset (sync, active-high): SDA released; BUSY=0; WR_STROBE=0; WR_ADDR=0; state=IDLE; address pointer=0; bit counter=0. Array contents are not cleared. RESET mid-transfer aborts the transfer at the next CLK edge.
- Input handling: SCL and SDA pass through SYNC_STAGES flops. scl_rise and scl_fall are 1-CLK pulses from the synchronized SCL. START = synced SDA 1->0 while synced SCL=1. STOP = synced SDA 0->1 while synced SCL=1.
- Sampling and driving: input bits are sampled on scl_rise. Slave SDA drive changes only on scl_fall, so SDA is stable while SCL is high.
- START in any state (including a repeated START): go to CTRL, bit counter=0, BUSY=1.
- STOP in any state: go to IDLE, release SDA, BUSY=0.
- States: IDLE, CTRL, CTRL_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- CTRL: shift 8 bits MSB first.
  - If bits[7:4] != DEV_TYPE: return to IDLE without ACK; SDA stays released; ignore the bus until the next START.
  - Else latch page = bits[3:1] into pointer[10:8].
  - R/W=0: go to CTRL_ACK, then ADDR.
  - R/W=1: go to CTRL_ACK, then RDATA.
- *_ACK states: pull SDA low from the scl_fall after the 8th bit through the next scl_fall (9th clock), then release.
- ADDR: shift 8 bits into pointer[7:0], then ADDR_ACK, then WDATA.
- WDATA: shift 8 bits.
  - On the 8th scl_rise: write array[pointer], pulse WR_STROBE, set WR_ADDR=pointer.
  - Then WDATA_ACK, pointer+1, back to WDATA for the next byte.
- RDATA: load shift register from array[pointer] on entry. Drive bit7..bit0 on successive scl_fall (a 1 bit means SDA released).
- RDATA_ACK: release SDA and sample the master's bit on the 9th scl_rise.
  - 0 (ACK): pointer+1, reload, continue RDATA.
  - 1 (NACK): go to IDLE, SDA released, wait for STOP.
- Pointer arithmetic: full MEM_AW bits, modulo 2**MEM_AW; 0x7FF+1 wraps to 0x000. Page bits in a later ctrl byte overwrite pointer[10:8].
- Random read: ctrl(W) + address, then repeated START, then ctrl(R) reads from the set pointer.
- A STOP immediately after ADDR_ACK leaves the pointer set and writes nothing.
- START/STOP detection takes priority over a coincident scl edge in the same CLK.

Decomposition:
- Shared package eeprom_pkg:
  - one-hot state localparams shared with EEPROM_WR naming;
  - DEV_TYPE constant;
  - ACK=0 / NACK=1 constants.
- Sub-module i2c_bus_sync: synchronizers plus scl_rise/scl_fall/start/stop pulse generation. Reusable by any future two-wire block.
- Array is an inferred reg array inside eeprom_slave.

Test Plan:
- Write: START, 0xA2 (page 1, W), 0x34, 0x5A, STOP -> ACK on all three bytes; WR_STROBE once with WR_ADDR=0x134; array[0x134]=0x5A; BUSY falls after STOP.
- Random read: preload array[0x134]=0x5A; START, 0xA2, 0x34, repeated START, 0xA3, master NACK, STOP -> slave shifts out 0x5A MSB first; SDA released after the NACK.
- Sequential write with wrap: START, 0xAE, 0xFF, 0x11, 0x22, STOP -> array[0x7FF]=0x11, array[0x000]=0x22, two WR_STROBE pulses.
- Wrong device: START, 0x52 -> no ACK (SDA stays high-z in the 9th clock); following bytes ignored; no WR_STROBE; BUSY low.
- Reset mid-read: assert RESET for 1 CLK during RDATA bit 4 -> SDA released the next CLK, BUSY=0, state IDLE; the next full write transaction completes normally.
- Sequential read: array[0x010..0x012]=0x01,0x02,0x03; random-read setup to 0x010, ACK, ACK, NACK -> bytes 0x01, 0x02, 0x03 returned in order.

Source files
------------

// File: rtl/eeprom_pkg.sv
// eeprom_pkg: shared definitions for the two-wire EEPROM blocks.
//   state_e          one-hot FSM encoding, state names shared with the EEPROM_WR master
//   EEPROM_DEV_TYPE  default device-type nibble expected in ctrl byte bits [7:4]
//   ACK / NACK       SDA level of the acknowledge bit
package eeprom_pkg;

    typedef enum logic [8:0] {
        ST_IDLE      = 9'b0_0000_0001,
        ST_CTRL      = 9'b0_0000_0010,
        ST_CTRL_ACK  = 9'b0_0000_0100,
        ST_ADDR      = 9'b0_0000_1000,
        ST_ADDR_ACK  = 9'b0_0001_0000,
        ST_WDATA     = 9'b0_0010_0000,
        ST_WDATA_ACK = 9'b0_0100_0000,
        ST_RDATA     = 9'b0_1000_0000,
        ST_RDATA_ACK = 9'b1_0000_0000
    } state_e;

    localparam logic [3:0] EEPROM_DEV_TYPE = 4'b1010;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/eeprom_slave_if.sv
// eeprom_slave_if: serial clock and status/write-report signals of eeprom_slave.
//   SCL        serial clock from the master
//   BUSY       high from accepted START until STOP or return to IDLE
//   WR_STROBE  one-CLK pulse per data byte committed to the array
//   WR_ADDR    address of the last committed write, valid with WR_STROBE
// SDA is open-drain and stays a plain inout wire on the module so it resolves as a real net.
interface eeprom_slave_if #(
    parameter int unsigned MEM_AW = 11
);
    logic              SCL;
    logic              BUSY;
    logic              WR_STROBE;
    logic [MEM_AW-1:0] WR_ADDR;

    modport slave  (input  SCL, output BUSY, output WR_STROBE, output WR_ADDR);
    modport master (output SCL, input  BUSY, input  WR_STROBE, input  WR_ADDR);
endinterface

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: synchronizes SCL/SDA into the local clock domain and derives
// single-CLK event pulses.
//   clk_i, rst_i   local clock, synchronous active-high reset
//   scl_i, sda_i   raw bus levels
//   sda_o          synchronized SDA level
//   scl_rise_o     SCL 0->1
//   scl_fall_o     SCL 1->0
//   start_o        SDA 1->0 while SCL stays high
//   stop_o         SDA 0->1 while SCL stays high
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    // Reset to the idle-bus level (both high) so no spurious events follow reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign sda_o      = sda_s;
    assign scl_rise_o =  scl_s && !scl_prev_q;
    assign scl_fall_o = !scl_s &&  scl_prev_q;
    // SCL must be high on both samples so an SDA edge racing an SCL edge is not a condition.
    assign start_o    = scl_s && scl_prev_q &&  sda_prev_q && !sda_s;
    assign stop_o     = scl_s && scl_prev_q && !sda_prev_q &&  sda_s;

endmodule

// File: rtl/eeprom_slave.sv
// eeprom_slave: two-wire serial EEPROM responder with a 2**MEM_AW x 8 array.
//   CLK    system clock, at least 8x the SCL rate
//   RESET  synchronous active-high reset (array contents are kept)
//   SDA    open-drain serial data: driven 0 or released, never driven 1
//   bus    eeprom_slave_if.slave: SCL in; BUSY, WR_STROBE, WR_ADDR out
// Ctrl byte = {DEV_TYPE, ADDR[MEM_AW-1:8], R/W}; address byte = ADDR[7:0].
// MEM_AW is expected in 9..11 so the page field fits ctrl bits [3:1].
module eeprom_slave
    import eeprom_pkg::*;
#(
    parameter int unsigned MEM_AW      = 11,
    parameter logic [3:0]  DEV_TYPE    = EEPROM_DEV_TYPE,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    inout  wire           SDA,
    eeprom_slave_if.slave bus
);

    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .scl_i      (bus.SCL),
        .sda_i      (SDA),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    logic [7:0]        mem_q [2**MEM_AW];
    state_e            state_q;
    logic [MEM_AW-1:0] ptr_q;
    logic [2:0]        bitcnt_q;
    logic [6:0]        shreg_q;      // bit 7 goes straight to SDA, so only 7 bits are held
    logic              rnw_q;
    logic              load_pend_q;  // reload the read byte on the next scl_fall
    logic              sda_oe_q;     // 1 = pull SDA low
    logic              busy_q;
    logic              wr_strobe_q;
    logic [MEM_AW-1:0] wr_addr_q;

    logic [7:0] byte_in;
    logic [7:0] rd_byte;

    assign byte_in = {shreg_q, sda_s};
    assign rd_byte = mem_q[ptr_q];

    // In each *_ACK state the first scl_fall asserts the ACK and the second one
    // releases it and moves on, so SDA only ever changes while SCL is low.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            rnw_q       <= 1'b0;
            load_pend_q <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            wr_strobe_q <= 1'b0;
            if (start_det) begin
                state_q     <= ST_CTRL;
                bitcnt_q    <= '0;
                busy_q      <= 1'b1;
                sda_oe_q    <= 1'b0;
                load_pend_q <= 1'b0;
            end else if (stop_det) begin
                state_q  <= ST_IDLE;
                busy_q   <= 1'b0;
                sda_oe_q <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: ;
                    ST_CTRL: begin
                        if (scl_rise) begin
                            shreg_q  <= byte_in[6:0];
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                if (byte_in[7:4] != DEV_TYPE) begin
                                    state_q <= ST_IDLE;
                                    busy_q  <= 1'b0;
                                end else begin
                                    ptr_q[MEM_AW-1:8] <= byte_in[MEM_AW-8:1];
                                    rnw_q             <= byte_in[0];
                                    state_q           <= ST_CTRL_ACK;
                                end
                            end
                        end
                    end
                    ST_CTRL_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else if (rnw_q) begin
                                state_q  <= ST_RDATA;
                                shreg_q  <= rd_byte[6:0];
                                sda_oe_q <= ~rd_byte[7];
                                bitcnt_q <= '0;
                            end else begin
                                state_q  <= ST_ADDR;
                                sda_oe_q <= 1'b0;
                                bitcnt_q <= '0;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shreg_q  <= byte_in[6:0];
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                ptr_q[7:0] <= byte_in;
                                state_q    <= ST_ADDR_ACK;
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else begin
                                state_q  <= ST_WDATA;
                                sda_oe_q <= 1'b0;
                                bitcnt_q <= '0;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (scl_rise) begin
                            shreg_q  <= byte_in[6:0];
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                mem_q[ptr_q] <= byte_in;
                                wr_strobe_q  <= 1'b1;
                                wr_addr_q    <= ptr_q;
                                ptr_q        <= ptr_q + 1'b1;
                                state_q      <= ST_WDATA_ACK;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (scl_fall) begin
                            if (load_pend_q) begin
                                shreg_q     <= rd_byte[6:0];
                                sda_oe_q    <= ~rd_byte[7];
                                load_pend_q <= 1'b0;
                            end else begin
                                shreg_q  <= {shreg_q[5:0], 1'b0};
                                sda_oe_q <= ~shreg_q[6];
                            end
                        end else if (scl_rise && !load_pend_q) begin
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                state_q <= ST_RDATA_ACK;
                            end
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe_q <= 1'b0;
                        end else if (scl_rise) begin
                            if (sda_s == ACK) begin
                                ptr_q       <= ptr_q + 1'b1;
                                load_pend_q <= 1'b1;
                                bitcnt_q    <= '0;
                                state_q     <= ST_RDATA;
                            end else begin
                                state_q  <= ST_IDLE;
                                busy_q   <= 1'b0;
                                sda_oe_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        busy_q   <= 1'b0;
                        sda_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign SDA           = sda_oe_q ? 1'b0 : 1'bz;
    assign bus.BUSY      = busy_q;
    assign bus.WR_STROBE = wr_strobe_q;
    assign bus.WR_ADDR   = wr_addr_q;

endmodule

// File: tb/tb_eeprom_slave.sv
// tb_eeprom_slave: directed two-wire master driving eeprom_slave, with a
// scoreboard queue of expected ACK/read bytes and a queue of expected write addresses.
module tb_eeprom_slave;

    localparam int unsigned MEM_AW = 11;
    localparam int unsigned Q      = 10;   // quarter SCL period in CLK cycles

    logic CLK = 1'b0;
    logic RESET;
    logic m_sda_low;
    wire  SDA;

    always #5 CLK = ~CLK;

    pullup (SDA);
    assign SDA = m_sda_low ? 1'b0 : 1'bz;

    eeprom_slave_if #(.MEM_AW(MEM_AW)) bus ();

    eeprom_slave #(
        .MEM_AW      (MEM_AW),
        .DEV_TYPE    (4'b1010),
        .SYNC_STAGES (2)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .SDA   (SDA),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t              sb_q[$];
    logic [MEM_AW-1:0] strobe_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic m_start();
        m_sda_low = 1'b0; tick(Q);
        bus.SCL   = 1'b1; tick(Q);
        m_sda_low = 1'b1; tick(Q);
        bus.SCL   = 1'b0; tick(Q);
    endtask

    task automatic m_stop();
        m_sda_low = 1'b1; tick(Q);
        bus.SCL   = 1'b1; tick(Q);
        m_sda_low = 1'b0; tick(Q);
    endtask

    task automatic m_wbit(input logic b);
        m_sda_low = ~b;  tick(Q);
        bus.SCL   = 1'b1; tick(2 * Q);
        bus.SCL   = 1'b0; tick(Q);
    endtask

    // Samples twice while SCL is high; the slave must not move SDA in between.
    task automatic m_rbit(output logic b);
        logic s1, s2;
        m_sda_low = 1'b0; tick(Q);
        bus.SCL   = 1'b1; tick(Q / 2);
        s1 = SDA;         tick(Q);
        s2 = SDA;
        check("sda_stable_scl_high", 32'(s2), 32'(s1));
        tick(Q / 2);
        bus.SCL   = 1'b0; tick(Q);
        b = s1;
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack);
        logic a;
        exp_t e;
        sb_q.push_back('{tag: $sformatf("ack_after_%02h", b), val: {7'd0, exp_ack}});
        for (int i = 7; i >= 0; i--) m_wbit(b[i]);
        m_rbit(a);
        e = sb_q.pop_front();
        check(e.tag, 32'(a), 32'(e.val));
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic m_ack);
        logic [7:0] d;
        logic       bt;
        exp_t       e;
        sb_q.push_back('{tag: "read_byte", val: exp});
        d = '0;
        for (int i = 0; i < 8; i++) begin
            m_rbit(bt);
            d = {d[6:0], bt};
        end
        m_wbit(m_ack);
        e = sb_q.pop_front();
        check(e.tag, 32'(d), 32'(e.val));
    endtask

    // Random-read setup: ctrl(W) + address, repeated START, ctrl(R).
    task automatic read_setup(input logic [10:0] addr);
        m_start();
        write_byte({4'b1010, addr[10:8], 1'b0}, 1'b0);
        write_byte(addr[7:0], 1'b0);
        m_start();
        write_byte({4'b1010, addr[10:8], 1'b1}, 1'b0);
    endtask

    // Every WR_STROBE pulse must match the next expected write address.
    initial begin
        forever begin
            @(negedge CLK);
            if (bus.WR_STROBE === 1'b1) begin
                if (strobe_q.size() == 0)
                    check("unexpected_wr_strobe", 32'(bus.WR_STROBE), 32'd0);
                else
                    check("wr_addr", 32'(bus.WR_ADDR), 32'(strobe_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic bt;
        RESET     = 1'b1;
        bus.SCL   = 1'b1;
        m_sda_low = 1'b0;
        tick(5);
        RESET = 1'b0;
        tick(3);
        check("rst_busy",      32'(bus.BUSY),      32'd0);
        check("rst_wr_strobe", 32'(bus.WR_STROBE), 32'd0);
        check("rst_wr_addr",   32'(bus.WR_ADDR),   32'd0);
        check("rst_sda",       32'(SDA),           32'd1);

        // Single write to 0x134
        strobe_q.push_back(11'h134);
        m_start();
        check("busy_after_start", 32'(bus.BUSY), 32'd1);
        write_byte(8'hA2, 1'b0);
        write_byte(8'h34, 1'b0);
        write_byte(8'h5A, 1'b0);
        m_stop();
        tick(5);
        check("busy_after_stop", 32'(bus.BUSY), 32'd0);

        // Random read of 0x134, master NACK
        read_setup(11'h134);
        read_byte(8'h5A, 1'b1);
        tick(2);
        check("sda_after_nack",  32'(SDA),      32'd1);
        check("busy_after_nack", 32'(bus.BUSY), 32'd0);
        m_stop();

        // Sequential write across the top of the array
        strobe_q.push_back(11'h7FF);
        strobe_q.push_back(11'h000);
        m_start();
        write_byte(8'hAE, 1'b0);
        write_byte(8'hFF, 1'b0);
        write_byte(8'h11, 1'b0);
        write_byte(8'h22, 1'b0);
        m_stop();
        read_setup(11'h7FF);
        read_byte(8'h11, 1'b0);
        read_byte(8'h22, 1'b1);
        m_stop();

        // Wrong device type: no ACK, rest of the transfer ignored
        m_start();
        write_byte(8'h52, 1'b1);
        check("busy_wrong_dev", 32'(bus.BUSY), 32'd0);
        write_byte(8'h34, 1'b1);
        write_byte(8'h99, 1'b1);
        m_stop();

        // Reset in the middle of a read while the slave pulls SDA low
        strobe_q.push_back(11'h020);
        m_start();
        write_byte(8'hA0, 1'b0);
        write_byte(8'h20, 1'b0);
        write_byte(8'h00, 1'b0);
        m_stop();
        read_setup(11'h020);
        m_rbit(bt);
        m_rbit(bt);
        m_rbit(bt);
        check("sda_driven_bit4", 32'(SDA), 32'd0);
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        check("sda_after_reset",  32'(SDA),      32'd1);
        check("busy_after_reset", 32'(bus.BUSY), 32'd0);
        tick(Q);
        strobe_q.push_back(11'h040);
        m_start();
        write_byte(8'hA0, 1'b0);
        write_byte(8'h40, 1'b0);
        write_byte(8'h77, 1'b0);
        m_stop();
        read_setup(11'h040);
        read_byte(8'h77, 1'b1);
        m_stop();

        // Sequential read of three bytes
        strobe_q.push_back(11'h010);
        strobe_q.push_back(11'h011);
        strobe_q.push_back(11'h012);
        m_start();
        write_byte(8'hA0, 1'b0);
        write_byte(8'h10, 1'b0);
        write_byte(8'h01, 1'b0);
        write_byte(8'h02, 1'b0);
        write_byte(8'h03, 1'b0);
        m_stop();
        read_setup(11'h010);
        read_byte(8'h01, 1'b0);
        read_byte(8'h02, 1'b0);
        read_byte(8'h03, 1'b1);
        m_stop();

        tick(20);
        check("strobes_outstanding",   32'(strobe_q.size()), 32'd0);
        check("scoreboard_outstanding", 32'(sb_q.size()),    32'd0);
        check("busy_end",              32'(bus.BUSY),        32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
